// File: rtl/rot_stream_sink.sv
// Receiving end of the rotated-video stream: writes pixels linearly into a
// double-buffered frame store, checks frame geometry, reports good/bad frames.
module rot_stream_sink #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int DEPTH  = 8,
  parameter int AW     = 17
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [DEPTH-1:0] video_in,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  output logic [AW-1:0]    wr_addr,
  output logic [DEPTH-1:0] wr_data,
  output logic             wr_en,
  output logic             disp_buf,
  output logic             frame_done,
  output logic             frame_err,
  output logic [9:0]       line_cnt
);

  localparam int BUFSIZE = WIDTH * HEIGHT;
  localparam int PW      = $clog2(HEIGHT + 1);

  localparam logic [AW-1:0] BASE1     = AW'(BUFSIZE);
  localparam logic [PW-1:0] HEIGHT_P  = PW'(HEIGHT);
  localparam logic [9:0]    WIDTH_P   = 10'(WIDTH);
  localparam logic [9:0]    WIDTH_SAT = 10'(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ARMED, LINE, GAP} state_t;

  state_t           state_q, state_d;
  logic             vsync_q, vsync_d;
  logic             wr_buf_q, wr_buf_d;
  logic [PW-1:0]    pix_q, pix_d;
  logic             err_q, err_d;
  logic             open_q, open_d;    // at least one pixel seen in the current line
  logic             first_q, first_d;  // next accepted pixel goes to base, not base+1
  logic [9:0]       line_cnt_q, line_cnt_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [DEPTH-1:0] wr_data_q, wr_data_d;
  logic             wr_en_q, wr_en_d;
  logic             disp_buf_q, disp_buf_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;

  // de alone qualifies data, so the line-gap marker carries no information here.
  logic unused_hsync;
  assign unused_hsync = hsync;

  logic vs_rise, vs_fall, pixel;
  assign vs_rise = vsync & ~vsync_q;
  assign vs_fall = ~vsync & vsync_q;
  assign pixel   = de & ~vsync;

  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    vsync_d    = vsync;
    wr_buf_d   = wr_buf_q;
    pix_d      = pix_q;
    err_d      = err_q;
    open_d     = open_q;
    first_d    = first_q;
    line_cnt_d = line_cnt_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    disp_buf_d = disp_buf_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;

    unique case (state_q)
      IDLE: if (vsync) state_d = ARMED;

      ARMED: begin
        if (vs_fall) begin
          line_cnt_d = '0;
          pix_d      = '0;
          err_d      = 1'b0;
          open_d     = 1'b0;
          first_d    = 1'b1;
          wr_addr_d  = wr_buf_q ? BASE1 : '0;
          state_d    = LINE;
        end
      end

      LINE, GAP: begin
        if (pixel) begin
          state_d = LINE;
          open_d  = 1'b1;
          if (pix_q < HEIGHT_P && line_cnt_q < WIDTH_P) begin
            wr_en_d   = 1'b1;
            wr_data_d = video_in;
            wr_addr_d = first_q ? wr_addr_q : wr_addr_q + 1'b1;
            first_d   = 1'b0;
            pix_d     = pix_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end

        // A pixel and a close are mutually exclusive: one needs de=1/vsync=0.
        if (state_q == LINE && open_q && (!de || vs_rise)) begin
          if (pix_q != HEIGHT_P) err_d = 1'b1;
          if (line_cnt_q != WIDTH_SAT) line_cnt_d = line_cnt_q + 10'd1;
          pix_d   = '0;
          open_d  = 1'b0;
          state_d = GAP;
        end

        // Frame verdict uses the counts after any same-cycle line close.
        if (vs_rise) begin
          if (line_cnt_d == WIDTH_P && !err_d) begin
            done_d     = 1'b1;
            disp_buf_d = wr_buf_q;
            wr_buf_d   = ~wr_buf_q;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = ARMED;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      vsync_q    <= 1'b0;
      wr_buf_q   <= 1'b0;
      pix_q      <= '0;
      err_q      <= 1'b0;
      open_q     <= 1'b0;
      first_q    <= 1'b0;
      line_cnt_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      disp_buf_q <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= vsync_d;
      wr_buf_q   <= wr_buf_d;
      pix_q      <= pix_d;
      err_q      <= err_d;
      open_q     <= open_d;
      first_q    <= first_d;
      line_cnt_q <= line_cnt_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      disp_buf_q <= disp_buf_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;
  assign disp_buf   = disp_buf_q;
  assign frame_done = done_q;
  assign frame_err  = ferr_q;
  assign line_cnt   = line_cnt_q;

endmodule

// File: tb/tb_rot_stream_sink.sv
// Bench for rot_stream_sink: frames described as lists of line lengths, with a
// frame-level model predicting writes, verdict, display buffer and line count.
module tb_rot_stream_sink;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int DEPTH  = 8;
  localparam int AW     = 5;
  localparam int BUFSIZE = WIDTH * HEIGHT;

  logic             clk_sys = 1'b0;
  logic             reset;
  logic [DEPTH-1:0] video_in;
  logic             hsync, vsync, de;
  logic [AW-1:0]    wr_addr;
  logic [DEPTH-1:0] wr_data;
  logic             wr_en, disp_buf, frame_done, frame_err;
  logic [9:0]       line_cnt;

  rot_stream_sink #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk_sys(clk_sys), .reset(reset), .video_in(video_in), .hsync(hsync),
    .vsync(vsync), .de(de), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .disp_buf(disp_buf), .frame_done(frame_done), .frame_err(frame_err),
    .line_cnt(line_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Observed write stream and pulse counts, collected away from the active edge.
  logic [31:0] got_addr[$], got_data[$];
  int n_done = 0, n_err = 0;

  always @(negedge clk_sys) begin
    if (wr_en) begin
      got_addr.push_back(32'(wr_addr));
      got_data.push_back(32'(wr_data));
    end
    if (frame_done) n_done++;
    if (frame_err)  n_err++;
  end

  // Frame-level model state.
  int          m_buf  = 0;
  int          m_disp = 0;
  logic [31:0] exp_addr[$], exp_data[$];
  int          lens_q[$];
  int          exp_done, exp_err, exp_lines;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_obs();
    got_addr.delete();
    got_data.delete();
    n_done = 0;
    n_err  = 0;
  endtask

  // Drive one frame whose line lengths are in lens_q, and predict its outcome.
  task automatic run_frame(input bit vs_on_last, input bit seq_data);
    int  base, k;
    bit  good;
    logic [DEPTH-1:0] d;
    base = (m_buf != 0) ? BUFSIZE : 0;
    k    = 0;
    good = (lens_q.size() == WIDTH);
    exp_addr.delete();
    exp_data.delete();

    // Pixels offered while vsync is high must be ignored.
    vsync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      de = 1'($urandom);
      video_in = DEPTH'($urandom);
      tick();
    end
    vsync = 1'b0;
    de    = 1'b0;
    tick();

    for (int l = 0; l < lens_q.size(); l++) begin
      if (lens_q[l] != HEIGHT) good = 1'b0;
      for (int j = 0; j < lens_q[l]; j++) begin
        d = seq_data ? DEPTH'(k + 1) : DEPTH'($urandom);
        if (l < WIDTH && j < HEIGHT) begin
          exp_addr.push_back(32'((base + k) % (1 << AW)));
          exp_data.push_back(32'(d));
          k++;
        end
        de = 1'b1;
        hsync = 1'($urandom);
        video_in = d;
        tick();
      end
      if (!(vs_on_last && l == lens_q.size() - 1)) begin
        de = 1'b0;
        hsync = 1'b1;
        for (int g = 0; g < 1 + int'($urandom_range(2)); g++) tick();
        hsync = 1'b0;
      end
    end

    vsync = 1'b1;
    de = 1'($urandom);
    tick();
    de = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    exp_lines = (lens_q.size() > WIDTH + 1) ? WIDTH + 1 : lens_q.size();
    exp_done  = good ? 1 : 0;
    exp_err   = good ? 0 : 1;
    if (good) begin
      m_disp = m_buf;
      m_buf  = 1 - m_buf;
    end
  endtask

  task automatic check_frame(input string tag);
    int n;
    check({tag, ".nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.addr%0d", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s.data%0d", tag, i), got_data[i], exp_data[i]);
    end
    check({tag, ".done"}, 32'(n_done), 32'(exp_done));
    check({tag, ".err"}, 32'(n_err), 32'(exp_err));
    check({tag, ".disp_buf"}, 32'(disp_buf), 32'(m_disp));
    check({tag, ".line_cnt"}, 32'(line_cnt), 32'(exp_lines));
    clear_obs();
  endtask

  task automatic set_lens(input int a, input int b, input int c, input int d, input int e);
    lens_q.delete();
    if (a > 0) lens_q.push_back(a);
    if (b > 0) lens_q.push_back(b);
    if (c > 0) lens_q.push_back(c);
    if (d > 0) lens_q.push_back(d);
    if (e > 0) lens_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl;
    reset = 1'b1; vsync = 1'b0; de = 1'b0; hsync = 1'b0; video_in = '0;
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk_sys);
    check("rst.wr_en", 32'(wr_en), 32'd0);
    check("rst.wr_addr", 32'(wr_addr), 32'd0);
    check("rst.wr_data", 32'(wr_data), 32'd0);
    check("rst.disp_buf", 32'(disp_buf), 32'd0);
    check("rst.pulses", 32'({frame_done, frame_err}), 32'd0);
    check("rst.line_cnt", 32'(line_cnt), 32'd0);
    reset = 1'b0;
    tick();
    clear_obs();

    // Good frame with data 1..12, then two more good frames: buffers alternate.
    set_lens(3, 3, 3, 3, 0); run_frame(1'b0, 1'b1); check_frame("good1");
    set_lens(3, 3, 3, 3, 0); run_frame(1'b0, 1'b0); check_frame("good2");
    set_lens(3, 3, 3, 3, 0); run_frame(1'b1, 1'b0); check_frame("good3");

    // Malformed frames: short line, extra line, too few lines, long line.
    set_lens(3, 2, 3, 3, 0); run_frame(1'b0, 1'b0); check_frame("short_line");
    set_lens(3, 3, 3, 3, 3); run_frame(1'b0, 1'b0); check_frame("five_lines");
    set_lens(3, 3, 3, 0, 0); run_frame(1'b0, 1'b0); check_frame("three_lines");
    set_lens(3, 4, 3, 3, 0); run_frame(1'b1, 1'b0); check_frame("long_line");
    set_lens(3, 3, 3, 3, 0); run_frame(1'b0, 1'b0); check_frame("good4");

    // Randomized frames, mostly well-formed.
    for (int r = 0; r < 12; r++) begin
      lens_q.delete();
      if ($urandom_range(9) < 6) begin
        repeat (WIDTH) lens_q.push_back(HEIGHT);
      end else begin
        nl = 3 + int'($urandom_range(2));
        repeat (nl) lens_q.push_back(2 + int'($urandom_range(2)));
      end
      run_frame(1'($urandom), 1'b0);
      check_frame($sformatf("rand%0d", r));
    end

    // Reset after 5 pixels of a frame; the rest of that frame must be ignored.
    vsync = 1'b1; tick(); tick();
    vsync = 1'b0; tick();
    for (int p = 0; p < 5; p++) begin
      de = 1'b1; video_in = DEPTH'($urandom); tick();
      if (p == 2) begin de = 1'b0; tick(); end
    end
    de = 1'b0;
    tick();
    check("pre_rst.nwr", 32'(got_addr.size()), 32'd5);
    clear_obs();
    reset = 1'b1; tick(); tick();
    reset = 1'b0;
    m_buf = 0; m_disp = 0;
    @(negedge clk_sys);
    check("midrst.disp_buf", 32'(disp_buf), 32'd0);
    check("midrst.wr_en", 32'(wr_en), 32'd0);
    #1;
    for (int p = 0; p < 7; p++) begin
      de = (p % 4) != 3; video_in = DEPTH'($urandom); tick();
    end
    de = 1'b0;
    tick();
    check("midrst.nwr", 32'(got_addr.size()), 32'd0);
    check("midrst.pulses", 32'(n_done + n_err), 32'd0);
    clear_obs();
    set_lens(3, 3, 3, 3, 0); run_frame(1'b0, 1'b0); check_frame("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
